// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe datapath.
// Holds the move-bus codes, the legal position range, the player bit
// encoding and the state encoding of the move-entry FSM.
package tictactoe_pkg;

    // Move bus codes understood by the game register block.
    localparam logic [4:0] MOVE_CLEAR = 5'b00000;
    // Position 15 with player 0. The game block treats this code as neither
    // a move nor a clear, so it holds its state.
    localparam logic [4:0] MOVE_IDLE  = 5'b01111;

    localparam logic [3:0] POS_MIN = 4'd1;
    localparam logic [3:0] POS_MAX = 4'd9;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    // True when the selector addresses a real board cell.
    function automatic logic pos_valid(input logic [3:0] pos);
        return (pos >= POS_MIN) && (pos <= POS_MAX);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser followed by a level debouncer.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   btn_raw  raw asynchronous button input
//   level_o  debounced button level
// The debounced level follows the synchronised level only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level_o
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // The mismatch seen on this edge is the DEBOUNCE_CYCLES-th in a row
            // when the counter already holds DEBOUNCE_CYCLES-1.
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/move_entry.sv
// Move entry stage for the tic-tac-toe game register block.
// Converts the Basys3 switch bank and pushbuttons into the 5-bit move word.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset (drives MOVE_CLEAR)
//   btn_submit   raw submit pushbutton
//   btn_clear    raw clear-board pushbutton
//   sw_pos       selected position, 1..9 valid
//   last_player  player who moved last, as reported by the game block
//   move         registered move word {player, position}, idle otherwise
//   move_err     one-cycle pulse on submit with an invalid position
module move_entry
    import tictactoe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_submit,
    input  logic       btn_clear,
    input  logic [3:0] sw_pos,
    input  logic       last_player,
    output logic [4:0] move,
    output logic       move_err
);

    logic       submit_db, clear_db;
    state_t     state_q, state_d;
    logic [4:0] move_q, move_d;
    logic       err_q, err_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_submit (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_submit),
        .level_o(submit_db)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_clear (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_clear),
        .level_o(clear_db)
    );

    always_comb begin
        state_d = state_q;
        move_d  = MOVE_IDLE;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Clear has priority; a simultaneous submit is swallowed by
                // the release wait that follows.
                if (clear_db) begin
                    move_d  = MOVE_CLEAR;
                    state_d = S_ISSUE;
                end else if (submit_db) begin
                    if (pos_valid(sw_pos)) begin
                        move_d  = {~last_player, sw_pos};
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_WAIT_REL;
                    end
                end
            end
            S_ISSUE: begin
                // The code went out on the last edge; move_d is already idle.
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!submit_db && !clear_db) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            move_q  <= MOVE_CLEAR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            err_q   <= err_d;
        end
    end

    assign move     = move_q;
    assign move_err = err_q;

endmodule
